// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, default widths, stage state type.
package mips_pkg;

  localparam int unsigned DwDefault = 32;
  localparam int unsigned RwDefault = 5;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0100;
  localparam logic [3:0] AluAnd  = 4'b0001;
  localparam logic [3:0] AluOr   = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0010;
  localparam logic [3:0] AluLui  = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0011;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSra  = 4'b1111;
  localparam logic [3:0] AluHamm = 4'b1011;

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StHaz
  } stage_st_e;

  // LUI reads only the immediate, so its rt field never creates a dependency.
  function automatic logic alu_is_lui(logic [3:0] aluc);
    return aluc[2:0] == 3'b110;
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side, forwarding and ALU-side signals of the ID/EX operand stage.
interface ex_operand_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          id_valid;
  logic          id_ready;
  logic [3:0]    id_aluc;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rn;
  logic [DW-1:0] id_qa;
  logic [DW-1:0] id_qb;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_sa;
  logic          id_aluimm;
  logic          id_shift;
  logic          id_wreg;
  logic          id_m2reg;

  logic          mem_wreg;
  logic          mem_m2reg;
  logic [RW-1:0] mem_rn;
  logic [DW-1:0] mem_alu;
  logic          wb_wreg;
  logic [RW-1:0] wb_rn;
  logic [DW-1:0] wb_data;

  logic          ex_ready;
  logic          ex_valid;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_aluc;
  logic [RW-1:0] ex_rn;
  logic          ex_wreg;
  logic          ex_m2reg;

  // Upstream/pipeline side: drives decode and forwarding, consumes the ALU operands.
  modport master (
    output id_valid, id_aluc, id_rs, id_rt, id_rn, id_qa, id_qb, id_imm, id_sa,
           id_aluimm, id_shift, id_wreg, id_m2reg,
           mem_wreg, mem_m2reg, mem_rn, mem_alu, wb_wreg, wb_rn, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_aluc, ex_rn, ex_wreg, ex_m2reg
  );

  // The operand stage itself.
  modport slave (
    input  id_valid, id_aluc, id_rs, id_rt, id_rn, id_qa, id_qb, id_imm, id_sa,
           id_aluimm, id_shift, id_wreg, id_m2reg,
           mem_wreg, mem_m2reg, mem_rn, mem_alu, wb_wreg, wb_rn, wb_data, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_aluc, ex_rn, ex_wreg, ex_m2reg
  );

endinterface

// File: rtl/fwd_mux.sv
// Per-source bypass select: MEM ALU result over WB write data over register-file value.
module fwd_mux #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic          mem_wreg_i,
  input  logic          mem_m2reg_i,
  input  logic [RW-1:0] mem_rn_i,
  input  logic [DW-1:0] mem_alu_i,
  input  logic          wb_wreg_i,
  input  logic [RW-1:0] wb_rn_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [DW-1:0] stored_i,
  output logic [DW-1:0] data_o
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet; that case is stalled, not bypassed.
  assign mem_hit = mem_wreg_i & ~mem_m2reg_i & (mem_rn_i == src_i);
  assign wb_hit  = wb_wreg_i & (wb_rn_i == src_i);

  always_comb begin
    data_o = stored_i;
    if (src_i != '0) begin
      if (mem_hit) begin
        data_o = mem_alu_i;
      end else if (wb_hit) begin
        data_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, bypasses MEM/WB, stalls on load-use.
// Optional EX_STALL_CNT_EN adds a free-running stall-cycle counter output.
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned RW = RwDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
`ifdef EX_STALL_CNT_EN
  output logic [31:0]          stall_cnt_o,
`endif
  ex_operand_stage_if.slave    bus_io
);

  typedef struct packed {
    logic [3:0]    aluc;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rn;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] imm;
    logic [4:0]    sa;
    logic          aluimm;
    logic          shift;
    logic          wreg;
    logic          m2reg;
  } fields_t;

  fields_t   fields_d, fields_q, fields_in;
  logic      valid_d, valid_q;
  logic      load;
  logic      hazard;
  logic      accept;
  logic      rs_used, rt_used, load_in_mem;
  logic [DW-1:0] fwd_a, fwd_b;
  stage_st_e st;

  assign fields_in = '{
    aluc:   bus_io.id_aluc,
    rs:     bus_io.id_rs,
    rt:     bus_io.id_rt,
    rn:     bus_io.id_rn,
    qa:     bus_io.id_qa,
    qb:     bus_io.id_qb,
    imm:    bus_io.id_imm,
    sa:     bus_io.id_sa,
    aluimm: bus_io.id_aluimm,
    shift:  bus_io.id_shift,
    wreg:   bus_io.id_wreg,
    m2reg:  bus_io.id_m2reg
  };

  assign rs_used     = ~fields_q.shift;
  assign rt_used     = ~fields_q.aluimm & ~alu_is_lui(fields_q.aluc);
  assign load_in_mem = bus_io.mem_wreg & bus_io.mem_m2reg & (bus_io.mem_rn != '0);
  assign hazard      = valid_q & load_in_mem &
                       (((bus_io.mem_rn == fields_q.rs) & rs_used) |
                        ((bus_io.mem_rn == fields_q.rt) & rt_used));

  always_comb begin
    st = StEmpty;
    if (valid_q) begin
      st = hazard ? StHaz : StFull;
    end
  end

  assign bus_io.ex_valid = (st == StFull);
  assign bus_io.id_ready = ~valid_q | (bus_io.ex_ready & ~hazard);
  assign accept          = bus_io.id_valid & bus_io.id_ready;

  always_comb begin
    valid_d = valid_q;
    load    = 1'b0;
    case (st)
      StEmpty: begin
        if (accept) begin
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      StFull: begin
        if (accept) begin
          load = 1'b1;
        end else if (bus_io.ex_ready) begin
          valid_d = 1'b0;
        end
      end
      StHaz: begin
        valid_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
    // A redirect squashes both the held and the offered instruction.
    if (flush_i) begin
      valid_d = 1'b0;
      load    = 1'b0;
    end
    fields_d = load ? fields_in : fields_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      fields_q <= '0;
    end else begin
      valid_q  <= valid_d;
      fields_q <= fields_d;
    end
  end

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_a (
    .src_i       (fields_q.rs),
    .mem_wreg_i  (bus_io.mem_wreg),
    .mem_m2reg_i (bus_io.mem_m2reg),
    .mem_rn_i    (bus_io.mem_rn),
    .mem_alu_i   (bus_io.mem_alu),
    .wb_wreg_i   (bus_io.wb_wreg),
    .wb_rn_i     (bus_io.wb_rn),
    .wb_data_i   (bus_io.wb_data),
    .stored_i    (fields_q.qa),
    .data_o      (fwd_a)
  );

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_b (
    .src_i       (fields_q.rt),
    .mem_wreg_i  (bus_io.mem_wreg),
    .mem_m2reg_i (bus_io.mem_m2reg),
    .mem_rn_i    (bus_io.mem_rn),
    .mem_alu_i   (bus_io.mem_alu),
    .wb_wreg_i   (bus_io.wb_wreg),
    .wb_rn_i     (bus_io.wb_rn),
    .wb_data_i   (bus_io.wb_data),
    .stored_i    (fields_q.qb),
    .data_o      (fwd_b)
  );

  assign bus_io.ex_a     = fields_q.shift  ? {{(DW-5){1'b0}}, fields_q.sa} : fwd_a;
  assign bus_io.ex_b     = fields_q.aluimm ? fields_q.imm : fwd_b;
  assign bus_io.ex_aluc  = fields_q.aluc;
  assign bus_io.ex_rn    = fields_q.rn;
  assign bus_io.ex_wreg  = fields_q.wreg;
  assign bus_io.ex_m2reg = fields_q.m2reg;

`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q & (hazard | ~bus_io.ex_ready)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: vector table plus hazard/flush/reset sequences.
module tb_ex_operand_stage;
  import mips_pkg::*;

  typedef struct {
    logic [3:0]  aluc;
    logic [4:0]  rs, rt, rn;
    logic [31:0] qa, qb, imm;
    logic [4:0]  sa;
    logic        aluimm, shift, wreg, m2reg;
    logic        mw, mm;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic        ww;
    logic [4:0]  wrn;
    logic [31:0] wdata;
    logic [31:0] ea, eb;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t tbl[12];

  ex_operand_stage_if #(.DW(32), .RW(5)) bus ();

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
`ifdef EX_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
`endif
    .bus_io      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [3:0] aluc, logic [4:0] rs, logic [4:0] rt, logic [4:0] rn,
                              logic [31:0] qa, logic [31:0] qb, logic [31:0] imm, logic [4:0] sa,
                              logic aluimm, logic shift, logic wreg, logic m2reg,
                              logic mw, logic mm, logic [4:0] mrn, logic [31:0] malu,
                              logic ww, logic [4:0] wrn, logic [31:0] wdata,
                              logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.aluc = aluc; v.rs = rs; v.rt = rt; v.rn = rn; v.qa = qa; v.qb = qb; v.imm = imm;
    v.sa = sa; v.aluimm = aluimm; v.shift = shift; v.wreg = wreg; v.m2reg = m2reg;
    v.mw = mw; v.mm = mm; v.mrn = mrn; v.malu = malu; v.ww = ww; v.wrn = wrn;
    v.wdata = wdata; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_id(input vec_t v);
    bus.id_aluc = v.aluc; bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rn = v.rn;
    bus.id_qa = v.qa; bus.id_qb = v.qb; bus.id_imm = v.imm; bus.id_sa = v.sa;
    bus.id_aluimm = v.aluimm; bus.id_shift = v.shift;
    bus.id_wreg = v.wreg; bus.id_m2reg = v.m2reg;
  endtask

  task automatic set_fwd(input logic mw, input logic mm, input logic [4:0] mrn,
                         input logic [31:0] malu, input logic ww, input logic [4:0] wrn,
                         input logic [31:0] wdata);
    bus.mem_wreg = mw; bus.mem_m2reg = mm; bus.mem_rn = mrn; bus.mem_alu = malu;
    bus.wb_wreg = ww; bus.wb_rn = wrn; bus.wb_data = wdata;
  endtask

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.a = v.ea; e.b = v.eb; e.aluc = v.aluc; e.rn = v.rn; e.wreg = v.wreg; e.m2reg = v.m2reg;
    return e;
  endfunction

  // Scoreboard check on every transfer to the ALU side.
  task automatic monitor();
    exp_t got, e;
    if (bus.ex_valid && bus.ex_ready) begin
      got = '{a: bus.ex_a, b: bus.ex_b, aluc: bus.ex_aluc, rn: bus.ex_rn,
              wreg: bus.ex_wreg, m2reg: bus.ex_m2reg};
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0h expected no transfer", got);
      end else begin
        e = sb.pop_front();
        chk("sb_out", {53'b0, got}, {53'b0, e});
      end
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    tbl[0]  = mk(AluAdd, 1, 2, 3, 5, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    tbl[1]  = mk(AluAdd, 3, 4, 5, 1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 3, 'hAA, 1, 3, 'hBB, 'hAA, 2);
    tbl[2]  = mk(AluAdd, 0, 4, 5, 'h11, 'h22, 0, 0, 0, 0, 1, 0, 1, 0, 0, 'hAA, 1, 0, 'hBB,
                 'h11, 'h22);
    tbl[3]  = mk(AluSub, 5, 6, 7, 'h10, 'h20, 0, 0, 0, 0, 1, 0, 1, 0, 7, 'h99, 1, 6, 'hCAFE,
                 'h10, 'hCAFE);
    tbl[4]  = mk(AluAnd, 8, 9, 10, 1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 9, 'h55, 1, 8, 'h66, 'h66, 'h55);
    tbl[5]  = mk(AluSll, 10, 10, 11, 'h123, 'hF0, 0, 31, 0, 1, 1, 0, 1, 0, 10, 'h77, 0, 0, 0,
                 'h1F, 'h77);
    tbl[6]  = mk(AluLui, 0, 4, 4, 'h321, 'h999, 'h1234, 0, 1, 0, 1, 0, 1, 1, 4, 'hDEAD, 0, 0, 0,
                 'h321, 'h1234);
    tbl[7]  = mk(AluOr, 12, 13, 14, 'hA, 'hB, 0, 0, 0, 0, 0, 1, 0, 0, 12, 'hEE, 0, 13, 'hFF,
                 'hA, 'hB);
    tbl[8]  = mk(AluXor, 13, 14, 15, 3, 4, 'hFFFF0000, 0, 1, 0, 1, 0, 1, 1, 20, 1, 1, 13, 'h5A5A,
                 'h5A5A, 'hFFFF0000);
    tbl[9]  = mk(AluHamm, 12, 12, 16, 1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 12, 'h3C, 1, 12, 'h4D,
                 'h3C, 'h3C);
    tbl[10] = mk(AluSra, 17, 18, 19, 'h80000000, 4, 0, 5, 0, 1, 1, 0, 1, 0, 17, 9, 1, 18, 8, 5, 8);
    tbl[11] = mk(AluAdd, 21, 0, 1, 'h21, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 'h77, 'h21, 0);

    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    drive_id(tbl[0]);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs", {bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_aluc, bus.ex_rn,
                       bus.ex_wreg, bus.ex_m2reg}, '0);
    chk("reset_id_ready", bus.id_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset while FULL and stalled.
    drive_id(tbl[0]);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b0;
    cyc();
    bus.id_valid = 1'b0;
    #1;
    chk("full_valid", bus.ex_valid, 1);
    chk("full_a", bus.ex_a, 5);
    chk("full_stall_ready", bus.id_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", {bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_aluc, bus.ex_rn,
                             bus.ex_wreg, bus.ex_m2reg}, '0);
    chk("async_reset_ready", bus.id_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Table: accept, then check output one cycle later with the vector's forwarding.
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      drive_id(v);
      set_fwd(v.mw, v.mm, v.mrn, v.malu, v.ww, v.wrn, v.wdata);
      bus.id_valid = 1'b1;
      bus.ex_ready = 1'b1;
      sb.push_back(exp_of(v));
      cyc();
      bus.id_valid = 1'b0;
      #1;
      chk($sformatf("lat_valid[%0d]", i), bus.ex_valid, 1);
      cyc();
    end
    #1;
    chk("drained", bus.ex_valid, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Load-use hazard on rt, resolved from WB one cycle later.
    v = mk(AluAdd, 1, 4, 9, 'h100, 'h777, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h100, 'h1234);
    drive_id(v);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b1;
    sb.push_back(exp_of(v));
    cyc();
    drive_id(tbl[3]);
    set_fwd(1, 1, 4, 'hBAD, 0, 0, 0);
    #1;
    chk("haz_ex_valid", bus.ex_valid, 0);
    chk("haz_id_ready", bus.id_ready, 0);
    cyc();
    bus.id_valid = 1'b0;
    set_fwd(0, 0, 0, 0, 1, 4, 'h1234);
    #1;
    chk("haz_clear_valid", bus.ex_valid, 1);
    chk("haz_wb_fwd_b", bus.ex_b, 'h1234);
    cyc();
    set_fwd(0, 0, 0, 0, 0, 0, 0);
`ifdef EX_STALL_CNT_EN
    chk("stall_cnt_haz", stall_cnt, 1);
`endif

    // Forwarded value tracks MEM while the ALU side is stalled.
    v = mk(AluAdd, 2, 3, 6, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h20, 2);
    drive_id(v);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b1;
    cyc();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    set_fwd(1, 0, 2, 'h10, 0, 0, 0);
    #1;
    chk("stall_fwd_a", bus.ex_a, 'h10);
    chk("stall_id_ready", bus.id_ready, 0);
    cyc();
    set_fwd(1, 0, 2, 'h20, 0, 0, 0);
    bus.ex_ready = 1'b1;
    sb.push_back(exp_of(v));
    cyc();
    set_fwd(0, 0, 0, 0, 0, 0, 0);

    // Flush beats acceptance into an empty stage.
    drive_id(tbl[4]);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("flush_empty_valid", bus.ex_valid, 0);
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();

    // Flush squashes a held, stalled instruction and the one offered with it.
    drive_id(tbl[5]);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b0;
    cyc();
    drive_id(tbl[6]);
    flush = 1'b1;
    #1;
    chk("held_before_flush", bus.ex_valid, 1);
    cyc();
    flush = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("flush_held_valid", bus.ex_valid, 0);
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("flush_stays_empty", bus.ex_valid, 0);
`ifdef EX_STALL_CNT_EN
    chk("stall_cnt_flush", stall_cnt, 3);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers one decoded instruction per handshake and selects the ALU operands a and b.
- Drives aluc and resolves RAW hazards by forwarding from the MEM and WB stages.
- Stalls for one cycle on a load-use hazard.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-number width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of the held instruction (branch/jump redirect)
- id_valid  in  1  decode stage offers an instruction
- id_ready  out  1  stage can accept this cycle
- id_aluc  in  4  ALU opcode
- id_rs, id_rt  in  RW  source register numbers
- id_rn  in  RW  destination register number
- id_qa, id_qb  in  DW  register-file read data for rs/rt
- id_imm  in  DW  extended immediate
- id_sa  in  5  shift amount
- id_aluimm  in  1  b takes imm instead of rt
- id_shift  in  1  a takes zero-extended sa instead of rs
- id_wreg  in  1  instruction writes a register
- id_m2reg  in  1  instruction is a load
- mem_wreg, mem_m2reg  in  1  MEM-stage writeback flags
- mem_rn  in  RW  MEM-stage destination
- mem_alu  in  DW  MEM-stage ALU result
- wb_wreg  in  1  WB-stage write enable
- wb_rn  in  RW  WB-stage destination
- wb_data  in  DW  WB-stage write data
- ex_ready  in  1  ALU side accepts this cycle
- ex_valid  out  1  operands on a/b are valid
- ex_a, ex_b  out  DW  ALU operands
- ex_aluc  out  4  ALU opcode
- ex_rn  out  RW  destination, passed through
- ex_wreg, ex_m2reg  out  1  control flags, passed through

Behaviour:
- Reset (async, immediate): valid=0 and every stored field=0.
  - Consequence: ex_valid=0, ex_a=ex_b=0, ex_aluc=0, ex_rn=0, ex_wreg=ex_m2reg=0, id_ready=1.
- States:
  - EMPTY (valid=0).
  - FULL (valid=1, no hazard).
  - HAZ (valid=1, load-use hazard pending).
- hazard: valid & mem_wreg & mem_m2reg & mem_rn!=0, and either:
  - mem_rn==rs and rs is used (~shift); or
  - mem_rn==rt and rt is used (~aluimm | aluc==x110 excluded).
  - Note: x110/LUI uses imm only. rt is used when ~aluimm.
- Outputs:
  - ex_valid = valid & ~hazard.
  - id_ready = ~valid | (ex_ready & ~hazard).
- Transfer: accept when id_valid & id_ready; all fields load at the next edge.
  - Latency: 1 cycle from acceptance to ex_valid.
- Drain without refill: valid clears when ex_ready & ex_valid & ~(id_valid & id_ready).
- HAZ: the stage holds its fields. The following cycle the load has moved to WB, the hazard clears, and the value is forwarded from wb_data. HAZ adds exactly 1 cycle.
- Forwarding, combinational on the stored rs/rt, every cycle:
  - Priority 1: MEM (mem_wreg & ~mem_m2reg & mem_rn==src & src!=0 -> mem_alu).
  - Priority 2: WB (wb_wreg & wb_rn==src & src!=0 -> wb_data).
  - Otherwise: the stored qa/qb.
  - Register 0 is never forwarded.
- Operand select:
  - ex_a = shift ? {27'b0, sa} : fwd_a.
  - ex_b = aluimm ? imm : fwd_b.
- The forwarded value is recomputed while stalled by ex_ready=0. It is not captured.
- flush: valid<=0 at the next edge. Flush wins over a simultaneous acceptance; the offered instruction is dropped and id_ready is ignored.
- Reset mid-stall clears everything. There is no residual hazard.

Optional Feature:
- Macro: EX_STALL_CNT_EN.
- When defined: adds output stall_cnt [31:0].
  - Increments on each cycle with valid & (hazard | ~ex_ready).
  - Wraps 0xFFFFFFFF -> 0.
  - Resets to 0; unaffected by flush.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants: ADD 4'b0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111, HAMM 1011.
  - DW and RW defaults.
- One sub-module, fwd_mux: given src, MEM and WB fields, and the stored value, it returns the forwarded word. Instantiate it twice (rs, rt).

Test Plan:
- Reset asserted mid-FULL -> all outputs 0 and id_ready=1 immediately, before the next clock edge.
- ADD: qa=5, qb=7, no hazards, ex_ready=1 -> one cycle later ex_valid=1, ex_a=5, ex_b=7, ex_aluc=0000.
- MEM forward beats WB: rs=3, mem_rn=3 with mem_alu=0xAA, wb_rn=3 with wb_data=0xBB -> ex_a=0xAA. With rs=0 and the same forwards -> ex_a=qa.
- Load-use:
  - MEM is load with rn=4 and the held instruction reads rt=4 -> ex_valid=0 and id_ready=0 for 1 cycle.
  - Next cycle, WB with rn=4 and wb_data=0x1234 -> ex_b=0x1234, ex_valid=1.
  - stall_cnt=1 when EX_STALL_CNT_EN is defined.
- SLL with sa=31 and aluimm=0 -> ex_a=0x0000001F. LUI with imm=0x00001234 -> ex_b=0x00001234, and rt is not checked for hazards.
- flush together with id_valid=1 and ex_ready=0 -> ex_valid=0 next cycle, and the offered instruction never appears on ex_*.
